// File: rtl/booth8_pkg.sv
//------------------------------------------------------------------------------
// Module   : booth8_pkg
// Purpose  : Constants, state encoding and helpers shared by the 8-bit Booth
//            multiplier and the booth_div8 non-restoring divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package booth8_pkg;

  // Operand width; the datapath is built for this value only.
  localparam int WIDTH = 8;

  // sign_mode bit positions, identical to the multiplier's convention.
  localparam int SM_DIVIDEND_BIT = 1;
  localparam int SM_DIVISOR_BIT  = 0;

  // Quotient bits produced per operation, one per RUN cycle.
  localparam int ITERATIONS = 8;
  localparam int CNT_W      = 3;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    magnitude = neg ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_div8_if.sv
//------------------------------------------------------------------------------
// Module   : booth_div8_if
// Purpose  : start/done request and result bundle of the 8-bit divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface booth_div8_if;
  import booth8_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [1:0]       sign_mode;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             busy;
  logic             done;

  // Requester side.
  modport master (
    output start, dividend, divisor, sign_mode,
    input  quotient, remainder, div_zero, busy, done
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor, sign_mode,
    output quotient, remainder, div_zero, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/booth_div8_nr_step.sv
//------------------------------------------------------------------------------
// Module   : div8_nr_step
// Purpose  : One combinational radix-2 non-restoring division step on the
//            partial remainder P, dividend/quotient shift register A and the
//            divisor magnitude D.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div8_nr_step
  import booth8_pkg::*;
(
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH:0]   d_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] a_o
);

  logic [WIDTH:0] p_shift;

  // Shift {P,A} left, add or subtract D, and shift the new quotient bit in.
  // The add/subtract decision uses the sign of P before the shift: with a
  // divisor magnitude up to 255 the shifted value can exceed the 9-bit signed
  // range, but the modular add/subtract result always lands back in [-D, D).
  always_comb begin
    p_shift = {p_i[WIDTH-1:0], a_i[WIDTH-1]};
    if (!p_i[WIDTH]) begin
      p_o = p_shift - d_i;
    end else begin
      p_o = p_shift + d_i;
    end
    a_o = {a_i[WIDTH-2:0], ~p_o[WIDTH]};
  end

endmodule

`default_nettype wire

// File: rtl/booth_div8.sv
//------------------------------------------------------------------------------
// Module   : booth_div8
// Purpose  : Sequential 8-bit radix-2 non-restoring divider producing quotient
//            and remainder with C truncation semantics. Operands are reduced to
//            magnitudes, divided over eight RUN cycles and sign-corrected in FIX.
//            Optional macro BOOTH_DIV8_DIVZERO_EN enables zero-divisor detection
//            (single-cycle bypass to FIX, quotient 0xFF, div_zero flag).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_div8
  import booth8_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  booth_div8_if.slave   div_if
);

  state_e           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic             neg_a, neg_b, zero_div;
  logic [WIDTH:0]   step_p;
  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] rem_mag;

  assign neg_a = div_if.sign_mode[SM_DIVIDEND_BIT] & div_if.dividend[WIDTH-1];
  assign neg_b = div_if.sign_mode[SM_DIVISOR_BIT]  & div_if.divisor[WIDTH-1];

`ifdef BOOTH_DIV8_DIVZERO_EN
  assign zero_div = (div_if.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  // Final restoring correction; the true remainder lies in [0, D) so eight
  // bits are enough.
  assign rem_mag = p_q[WIDTH-1:0] + (p_q[WIDTH] ? d_q : '0);

  div8_nr_step u_step (
    .p_i (p_q),
    .a_i (a_q),
    .d_i ({1'b0, d_q}),
    .p_o (step_p),
    .a_o (step_a)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      a_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      a_q         <= a_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  // Next-state, datapath update and result fix-up.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    a_d         = a_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (div_if.start) begin
          q_neg_d = neg_a ^ neg_b;
          r_neg_d = neg_a;
          p_d     = '0;
          a_d     = magnitude(div_if.dividend, neg_a);
          d_d     = magnitude(div_if.divisor, neg_b);
          cnt_d   = CNT_W'(ITERATIONS - 1);
          dz_d    = zero_div;
          if (zero_div) begin
            // Keep the raw dividend so it can be returned untouched.
            a_d     = div_if.dividend;
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = step_p;
        a_d   = step_a;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = a_q;
          div_zero_d  = 1'b1;
        end else begin
          quotient_d  = magnitude(a_q, q_neg_q);
          remainder_d = magnitude(rem_mag, r_neg_q);
          div_zero_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign div_if.quotient  = quotient_q;
  assign div_if.remainder = remainder_q;
  assign div_if.div_zero  = div_zero_q;
  assign div_if.busy      = (state_q != IDLE);
  assign div_if.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_div8.sv
//------------------------------------------------------------------------------
// Module   : tb_booth_div8
// Purpose  : Self-checking bench for booth_div8: directed vector table,
//            handshake corner cases and random operands against an
//            integer-arithmetic reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_booth_div8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  booth_div8_if bus ();

  booth_div8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sm;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // C-style division of the operands as interpreted by sign_mode, wrapped
  // to eight bits.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  input logic [1:0] sm,
                                  output logic [7:0] q, output logic [7:0] r);
    int av, bv, qi, ri;
    av = sm[1] ? int'($signed(a)) : int'(a);
    bv = sm[0] ? int'($signed(b)) : int'(b);
    qi = av / bv;
    ri = av % bv;
    q  = qi[7:0];
    r  = ri[7:0];
  endfunction

  // Called one time unit after a rising edge. Returns the number of edges
  // from acceptance to the done pulse (-1 on timeout) and the number of
  // sampled cycles with busy high.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    if (bus.busy) bcnt++;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL timeout: got no done, expected done within 20 cycles");
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] sm, output int lat, output int bcnt);
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.sign_mode = sm;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.dividend  = 8'h00;
    bus.divisor   = 8'h00;
    wait_done(lat, bcnt);
  endtask

  initial begin
    int         lat, bcnt;
    logic [7:0] eq, er, a, b;
    logic [1:0] sm;
    logic       saw_done;

    errors = 0;
    checks = 0;

    vecs[0] = '{8'd200, 8'h07, 2'b00, 8'h1C, 8'h04};
    vecs[1] = '{8'h9C, 8'h07, 2'b11, 8'hF2, 8'hFE};
    vecs[2] = '{8'h9C, 8'h07, 2'b00, 8'h16, 8'h02};
    vecs[3] = '{8'h80, 8'hFF, 2'b11, 8'h80, 8'h00};
    vecs[4] = '{8'h64, 8'hF9, 2'b01, 8'hF2, 8'h02};
    vecs[5] = '{8'hFF, 8'hFF, 2'b00, 8'h01, 8'h00};
    vecs[6] = '{8'h05, 8'h09, 2'b11, 8'h00, 8'h05};
    vecs[7] = '{8'h80, 8'h01, 2'b10, 8'h80, 8'h00};
    vecs[8] = '{8'h80, 8'h80, 2'b11, 8'h01, 8'h00};
    vecs[9] = '{8'h07, 8'h80, 2'b01, 8'h00, 8'h07};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.dividend  = 8'h00;
    bus.divisor   = 8'h00;
    bus.sign_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_quotient",  int'(bus.quotient),  0);
    chk("reset_remainder", int'(bus.remainder), 0);
    chk("reset_div_zero",  int'(bus.div_zero),  0);
    chk("reset_busy",      int'(bus.busy),      0);
    chk("reset_done",      int'(bus.done),      0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sm, lat, bcnt);
      chk($sformatf("vec%0d_quotient", i),  int'(bus.quotient),  int'(vecs[i].q));
      chk($sformatf("vec%0d_remainder", i), int'(bus.remainder), int'(vecs[i].r));
      chk($sformatf("vec%0d_div_zero", i),  int'(bus.div_zero),  0);
      chk($sformatf("vec%0d_latency", i),   lat,  9);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 9);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), int'(bus.done), 0);
    end

    // A start pulse at E3 while running must be ignored.
    bus.start     = 1'b1;
    bus.dividend  = 8'd100;
    bus.divisor   = 8'd9;
    bus.sign_mode = 2'b00;
    @(posedge clk); #1;                 // E0
    bus.start = 1'b0;
    @(posedge clk); #1;                 // E1
    @(posedge clk); #1;                 // E2
    bus.start     = 1'b1;
    bus.dividend  = 8'd50;
    bus.divisor   = 8'd3;
    @(posedge clk); #1;                 // E3
    bus.start = 1'b0;
    saw_done  = 1'b0;
    lat       = -1;
    for (int n = 4; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    chk("ignore_latency",   lat, 9);
    chk("ignore_quotient",  int'(bus.quotient),  11);
    chk("ignore_remainder", int'(bus.remainder), 1);
    // Start in the done cycle is accepted immediately.
    do_op(8'd50, 8'd3, 2'b00, lat, bcnt);
    chk("b2b_latency",   lat, 9);
    chk("b2b_quotient",  int'(bus.quotient),  16);
    chk("b2b_remainder", int'(bus.remainder), 2);
    @(posedge clk); #1;

    // Reset mid-operation aborts without a done pulse.
    bus.start     = 1'b1;
    bus.dividend  = 8'd77;
    bus.divisor   = 8'd5;
    bus.sign_mode = 2'b00;
    @(posedge clk); #1;                 // E0
    bus.start = 1'b0;
    repeat (4) @(posedge clk);          // E1..E4
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_quotient",  int'(bus.quotient),  0);
    chk("abort_remainder", int'(bus.remainder), 0);
    chk("abort_busy",      int'(bus.busy),      0);
    chk("abort_done",      int'(bus.done),      0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("abort_no_done", int'(saw_done), 0);
    do_op(8'd77, 8'd5, 2'b00, lat, bcnt);
    chk("after_abort_latency",   lat, 9);
    chk("after_abort_quotient",  int'(bus.quotient),  15);
    chk("after_abort_remainder", int'(bus.remainder), 2);
    @(posedge clk); #1;

`ifdef BOOTH_DIV8_DIVZERO_EN
    do_op(8'h5A, 8'h00, 2'b00, lat, bcnt);
    chk("dz_latency",   lat, 1);
    chk("dz_busy",      bcnt, 1);
    chk("dz_quotient",  int'(bus.quotient),  8'hFF);
    chk("dz_remainder", int'(bus.remainder), 8'h5A);
    chk("dz_flag",      int'(bus.div_zero),  1);
    @(posedge clk); #1;
    chk("dz_hold_flag", int'(bus.div_zero),  1);
    do_op(8'h5A, 8'h03, 2'b00, lat, bcnt);
    chk("dz_clear_quotient",  int'(bus.quotient),  8'h1E);
    chk("dz_clear_remainder", int'(bus.remainder), 8'h00);
    chk("dz_clear_flag",      int'(bus.div_zero),  0);
    @(posedge clk); #1;
`endif

    // Random operands against the reference model.
    for (int k = 0; k < 150; k++) begin
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(1, 255));
      sm = 2'($urandom_range(0, 3));
      ref_div(a, b, sm, eq, er);
      do_op(a, b, sm, lat, bcnt);
      chk($sformatf("rand%0d_q_%0h_%0h_%0b", k, a, b, sm), int'(bus.quotient),  int'(eq));
      chk($sformatf("rand%0d_r_%0h_%0h_%0b", k, a, b, sm), int'(bus.remainder), int'(er));
      if ((k % 4) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
